// File: rtl/switch_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// switch_debouncer_pkg
//   Shared board constants and types for the slide-switch debouncer.
//   CLK_HZ               : board system clock frequency.
//   DEBOUNCE_CYCLES_10MS : clocks in 10 ms, used as the default settle time.
//   db_state_e           : per-bit debounce FSM state.
// -----------------------------------------------------------------------------
package switch_debouncer_pkg;

    localparam int CLK_HZ               = 50_000_000;
    localparam int DEBOUNCE_CYCLES_10MS = CLK_HZ / 100;

    typedef enum logic {
        ST_STABLE  = 1'b0,  // synchronised input agrees with the output
        ST_PENDING = 1'b1   // input disagrees; counting consecutive mismatches
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   Two-flop synchroniser, stability counter and accept logic for one switch.
//   Ports:
//     i_clk    : system clock
//     i_rst_n  : asynchronous active-low reset
//     i_sw     : raw asynchronous switch pin
//     o_sw     : debounced level (registered)
//     o_rise   : one-cycle pulse on an accepted 0->1 change (registered)
//     o_fall   : one-cycle pulse on an accepted 1->0 change (registered)
//     o_accept : high in the cycle before o_rise/o_fall pulse, so the parent
//                can register its OR into a flag aligned with the pulses
// -----------------------------------------------------------------------------
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             s;
    db_state_e        state;
    db_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sw_next;
    logic             rise_next;
    logic             fall_next;

    // NOTE: every flop here uses non-blocking assignment so all registers
    // sample their inputs from the same edge, whatever the statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            state  <= ST_STABLE;
            cnt    <= '0;
            o_sw   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync1  <= i_sw;
            s      <= sync1;
            state  <= state_next;
            cnt    <= cnt_next;
            o_sw   <= sw_next;
            o_rise <= rise_next;
            o_fall <= fall_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        sw_next    = o_sw;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        case (state)
            ST_STABLE: begin
                if (s != o_sw) begin
                    state_next = ST_PENDING;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (s == o_sw) begin
                    // Bounce returned to the accepted level: discard the run.
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Accepting clears the counter, so it can never wrap.
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                    sw_next    = s;
                    rise_next  = s;
                    fall_next  = !s;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_STABLE;
                cnt_next   = '0;
            end
        endcase

        o_accept = rise_next | fall_next;
    end

endmodule

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Synchronises and debounces WIDTH raw slide switches; each bit settles
//   independently after STABLE_CYCLES consecutive clocks at a new level.
//   Ports:
//     i_clk     : system clock
//     i_rst_n   : asynchronous active-low reset
//     i_sw      : raw asynchronous switch pins
//     o_sw      : debounced switch levels
//     o_rise    : per-bit one-cycle pulse on an accepted 0->1 change
//     o_fall    : per-bit one-cycle pulse on an accepted 1->0 change
//     o_changed : one-cycle flag, OR of all o_rise/o_fall bits, same cycle
// -----------------------------------------------------------------------------
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_changed
);

    logic [WIDTH-1:0] accept;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sw    (i_sw[b]),
            .o_sw    (o_sw[b]),
            .o_rise  (o_rise[b]),
            .o_fall  (o_fall[b]),
            .o_accept(accept[b])
        );
    end

    // Registered from the same next-cycle accept terms as the pulses, so the
    // flag lines up with o_rise/o_fall without a combinational OR on outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_changed <= 1'b0;
        end else begin
            o_changed <= |accept;
        end
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the raw slide-switch inputs from the board pins and presents clean, glitch-free switch levels to the seven-segment display top (value select on SW[7:0], hex/decimal mode on SW[8], LEDR mirror). Each bit has a two-flop synchroniser and an independent stability counter. A bit's output changes only after its synchronised input has held a new level for STABLE_CYCLES consecutive clocks. Single-cycle rise/fall event pulses are provided for downstream logic that reacts to switch edges.

## Interface
- WIDTH, 10: number of switch bits handled.
- STABLE_CYCLES, 500000: consecutive clocks a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is 2 or more; simulation uses 4.
- i_clk  input  1  system clock (50 MHz on board).
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- i_sw  input  WIDTH  raw, asynchronous switch pins.
- o_sw  output  WIDTH  debounced switch levels. Reset value: all 0.
- o_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change. Reset value: 0.
- o_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change. Reset value: 0.
- o_changed  output  1  registered OR of all o_rise and o_fall bits, asserted in the same cycle as them. Reset value: 0.

## Operation
- Per bit, the synchroniser chain is sync1 <= i_sw[b], then s <= sync1. Both flops reset to 0.
- Each bit has a two-state FSM:
  - STABLE: s == o_sw[b] and cnt = 0.
  - PENDING: s != o_sw[b]; cnt counts consecutive mismatching edges.
- Transitions, evaluated every edge:
  - STABLE -> PENDING when s != o_sw[b], with cnt <= 1.
  - PENDING, s == o_sw[b] (bounce returned): go to STABLE, cnt <= 0, no output change.
  - PENDING, s != o_sw[b], cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - PENDING, s != o_sw[b], cnt == STABLE_CYCLES-1: o_sw[b] <= s, pulse o_rise[b] or o_fall[b] for one cycle, cnt <= 0, go to STABLE.
- cnt width is $clog2(STABLE_CYCLES). The counter never wraps; the accept condition clears it first.
- Bits are fully independent. Several bits may be accepted on the same edge; every affected rise/fall bit pulses, and o_changed pulses once.
- A change of direction during PENDING is impossible for a single bit, because s is binary and compared against a fixed o_sw.

## Timing
- Let i_sw[b] change and be sampled first at edge 0.
- s reflects the new value after edge 1.
- Mismatches are counted on edges 2 .. STABLE_CYCLES+1.
- o_sw[b] and its pulse update at edge STABLE_CYCLES+1, so latency is STABLE_CYCLES+2 edges including the sampling edge.
- Pulses are high for exactly one cycle and are deasserted on the next edge unless a different bit is accepted on that edge.
- A glitch whose synchronised width is shorter than STABLE_CYCLES clocks never reaches o_sw.
- Asynchronous reset mid-count clears all synchronisers, counters, o_sw and the pulses immediately.
- After reset release, switches held high are accepted STABLE_CYCLES+2 edges later, and o_rise pulses for them. Downstream logic must tolerate this start-up pulse.
- No combinational path exists from i_sw to any output.

## Structure
- A shared board package holds CLK_HZ = 50_000_000 and DEBOUNCE_CYCLES_10MS = 500_000. The top level passes the latter as STABLE_CYCLES.
- One sub-module, debounce_bit, contains the synchroniser, cnt, the FSM, o_sw and the rise/fall flops for a single bit.
- switch_debouncer instantiates debounce_bit WIDTH times in a generate loop and registers o_changed.

## Test plan
All scenarios use STABLE_CYCLES=4 and WIDTH=10.
- Reset with i_sw=10'h3FF held: all outputs are 0 during reset. At edge 6 after release, o_sw=10'h3FF, o_rise=10'h3FF and o_changed=1 for one cycle.
- From o_sw=0, set i_sw[3]=1 and hold: o_sw[3] rises exactly 6 edges after first sampling; o_rise[3] is high one cycle; o_fall stays 0.
- Bounce on i_sw[0]: the pattern 1,1,1,0,1,1,1,1 (one value per clock) is accepted only after the final four consecutive 1s, and o_rise[0] pulses exactly once.
- Glitch: a 3-clock 1 pulse on i_sw[8] produces no change on o_sw and no pulses.
- Simultaneous changes: i_sw changes from 10'h0F0 to 10'h10F on one edge. On a single edge o_sw=10'h10F, o_rise=10'h10F, o_fall=10'h0F0 and o_changed=1 for one cycle.
- Assert i_rst_n low 2 cycles into a pending change on i_sw[5]: o_sw returns to 0 immediately. After release, if i_sw[5] is still high, acceptance takes a full 6 edges again.
